// File: rtl/online_div_pkg.sv
// Shared definitions for the on-line divider datapath.
//   SD_*     : signed-digit encodings {plus,minus}; 2'b11 is illegal.
//   state_e  : on-the-fly converter FSM states.
//   sd_value : maps a signed-digit code to -1/0/+1 (illegal -> 0).
package online_div_pkg;

    localparam logic [1:0] SD_POS  = 2'b10;
    localparam logic [1:0] SD_NEG  = 2'b01;
    localparam logic [1:0] SD_ZERO = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_e;

    function automatic logic signed [1:0] sd_value(input logic [1:0] d);
        case (d)
            SD_POS:  return 2'sd1;
            SD_NEG:  return -2'sd1;
            default: return 2'sd0;
        endcase
    endfunction

endpackage

// File: rtl/otf_step.sv
// One on-the-fly conversion step (purely combinational).
//   q_i, qm_i : current Q and QM (= Q - 1 ulp), W bits two's complement
//   digit_i   : signed digit code {plus,minus}
//   q_o, qm_o : Q and QM after appending the digit
// The "+1" in each rule is just a 1 shifted into the LSB, so no adder.
module otf_step
    import online_div_pkg::*;
#(
    parameter int W = 9
) (
    input  logic [W-1:0] q_i,
    input  logic [W-1:0] qm_i,
    input  logic [1:0]   digit_i,
    output logic [W-1:0] q_o,
    output logic [W-1:0] qm_o
);

    logic signed [1:0] val;

    always_comb begin
        val  = sd_value(digit_i);
        q_o  = {q_i[W-2:0], 1'b0};
        qm_o = {qm_i[W-2:0], 1'b1};
        if (val == 2'sd1) begin
            q_o  = {q_i[W-2:0], 1'b1};
            qm_o = {q_i[W-2:0], 1'b0};
        end else if (val == -2'sd1) begin
            q_o  = {qm_i[W-2:0], 1'b1};
            qm_o = {qm_i[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/online_otf_converter.sv
// Serial signed-digit (MSD first) to two's-complement converter.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : digit handshake; in_first marks a word's MSD
//   in_digit             : {plus,minus} signed digit, 11 treated as 0
//   out_valid/out_ready  : result handshake
//   result               : N+1 bit signed quotient, held between words
//   digit_cnt            : digits accepted in the current word
//   proto_err            : registered pulse on illegal digit / restart /
//                          digit dropped in IDLE without in_first
module online_otf_converter
    import online_div_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_first,
    input  logic [1:0]    in_digit,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N:0]    result,
    output logic [CW-1:0] digit_cnt,
    output logic          proto_err
);

    state_e        state_q, state_d;
    logic [N:0]    q_q, q_d, qm_q, qm_d, result_q, result_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic          accept, restart;
    logic [N:0]    base_q, base_qm, step_q, step_qm;

    assign in_ready  = !rst && (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign digit_cnt = cnt_q;
    assign proto_err = err_q;

    assign accept  = in_valid && in_ready;
    // A new word always starts from Q=0 / QM=-1, whether from IDLE or a restart.
    assign restart = (state_q == IDLE) || in_first;
    assign base_q  = restart ? '0 : q_q;
    assign base_qm = restart ? '1 : qm_q;

    otf_step #(.W(N + 1)) u_step (
        .q_i    (base_q),
        .qm_i   (base_qm),
        .digit_i(in_digit),
        .q_o    (step_q),
        .qm_o   (step_qm)
    );

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        qm_d     = qm_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE, CONV: begin
                if (accept) begin
                    if (state_q == IDLE && !in_first) begin
                        err_d = 1'b1;
                    end else begin
                        q_d   = step_q;
                        qm_d  = step_qm;
                        cnt_d = restart ? CW'(1) : cnt_q + 1'b1;
                        err_d = (in_digit == 2'b11) || (state_q == CONV && in_first);
                        // Also covers N=1, where the first digit completes the word.
                        if (cnt_d == CW'(N)) begin
                            state_d  = DONE;
                            result_d = step_q;
                        end else begin
                            state_d = CONV;
                        end
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            q_q      <= '0;
            qm_q     <= '1;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            qm_q     <= qm_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    a_qm_shadow: assert property (@(posedge clk) disable iff (rst)
        qm_q == q_q - (N + 1)'(1));

endmodule
